// File: rtl/bs_engine_scheduler.sv
// Dispatches option records round-robin to idle Black-Scholes engines and
// returns tagged results on a single valid/ready stream, also round-robin.
module bs_engine_scheduler #(
    parameter int NUM_ENG = 4,
    parameter int W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rec_valid,
    input  logic [W-1:0]         rec_option_id,
    input  logic [W-1:0]         rec_sptprice,
    input  logic [W-1:0]         rec_strike,
    input  logic [W-1:0]         rec_rate,
    input  logic [W-1:0]         rec_volatility,
    input  logic [W-1:0]         rec_otime,
    input  logic [W-1:0]         rec_otype,
    output logic                 rec_ready,
    output logic [NUM_ENG-1:0]   eng_start,
    output logic [W-1:0]         eng_sptprice,
    output logic [W-1:0]         eng_strike,
    output logic [W-1:0]         eng_rate,
    output logic [W-1:0]         eng_volatility,
    output logic [W-1:0]         eng_otime,
    output logic [W-1:0]         eng_otype,
    input  logic [NUM_ENG-1:0]   eng_done,
    input  logic [NUM_ENG*W-1:0] eng_price,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [W-1:0]         res_option_id,
    output logic [W-1:0]         res_price,
    output logic [2:0]           res_engine,
    output logic [15:0]          ovf_cnt,
    output logic                 proto_err
);
    localparam int PW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
    localparam logic [PW:0] NE = (PW+1)'(NUM_ENG);

    typedef enum logic [1:0] {ENG_IDLE, ENG_BUSY, ENG_DONE} eng_state_t;

    eng_state_t    state      [NUM_ENG];
    eng_state_t    state_next [NUM_ENG];
    logic [W-1:0]  tag        [NUM_ENG];
    logic [W-1:0]  price      [NUM_ENG];
    logic [PW-1:0] disp_ptr, disp_sel;
    logic [PW-1:0] res_ptr, res_sel;
    logic          res_found;
    logic          accept, handshake;

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int unsigned off);
        logic [PW:0] s;
        s = {1'b0, base} + (PW+1)'(off);
        if (s >= NE) s = s - NE;
        return s[PW-1:0];
    endfunction

    assign accept    = rec_valid & rec_ready;
    assign handshake = res_valid & res_ready;

    // Both searches scan from their pointer upward with wrap; first hit wins.
    always_comb begin
        rec_ready = 1'b0;
        disp_sel  = '0;
        res_found = 1'b0;
        res_sel   = '0;
        for (int unsigned i = 0; i < NUM_ENG; i++) begin
            if (!rec_ready && state[wrap_add(disp_ptr, i)] == ENG_IDLE) begin
                rec_ready = 1'b1;
                disp_sel  = wrap_add(disp_ptr, i);
            end
            if (!res_found && state[wrap_add(res_ptr, i)] == ENG_DONE) begin
                res_found = 1'b1;
                res_sel   = wrap_add(res_ptr, i);
            end
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < NUM_ENG; k++) begin
            state_next[k] = state[k];
            case (state[k])
                ENG_IDLE: if (accept && disp_sel == PW'(k)) state_next[k] = ENG_BUSY;
                ENG_BUSY: if (eng_done[k]) state_next[k] = ENG_DONE;
                ENG_DONE: if (handshake && res_engine == 3'(k)) state_next[k] = ENG_IDLE;
                default:  state_next[k] = ENG_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < NUM_ENG; k++) state[k] <= ENG_IDLE;
        end else begin
            for (int unsigned k = 0; k < NUM_ENG; k++) state[k] <= state_next[k];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            eng_start      <= '0;
            eng_sptprice   <= '0;
            eng_strike     <= '0;
            eng_rate       <= '0;
            eng_volatility <= '0;
            eng_otime      <= '0;
            eng_otype      <= '0;
            disp_ptr       <= '0;
            res_ptr        <= '0;
            res_valid      <= 1'b0;
            res_option_id  <= '0;
            res_price      <= '0;
            res_engine     <= '0;
            ovf_cnt        <= '0;
            proto_err      <= 1'b0;
            for (int unsigned k = 0; k < NUM_ENG; k++) begin
                tag[k]   <= '0;
                price[k] <= '0;
            end
        end else begin
            eng_start <= '0;
            if (accept) begin
                eng_start[disp_sel] <= 1'b1;
                eng_sptprice        <= rec_sptprice;
                eng_strike          <= rec_strike;
                eng_rate            <= rec_rate;
                eng_volatility      <= rec_volatility;
                eng_otime           <= rec_otime;
                eng_otype           <= rec_otype;
                tag[disp_sel]       <= rec_option_id;
                disp_ptr            <= wrap_add(disp_sel, 1);
            end
            if (rec_valid && !rec_ready && ovf_cnt != '1) ovf_cnt <= ovf_cnt + 16'd1;
            for (int unsigned k = 0; k < NUM_ENG; k++) begin
                if (eng_done[k]) begin
                    if (state[k] == ENG_BUSY) price[k] <= eng_price[k*W +: W];
                    else                      proto_err <= 1'b1;
                end
            end
            // A new result is only chosen while the output slot is empty.
            if (handshake) begin
                res_valid <= 1'b0;
            end else if (!res_valid && res_found) begin
                res_valid     <= 1'b1;
                res_option_id <= tag[res_sel];
                res_price     <= price[res_sel];
                res_engine    <= 3'(res_sel);
                res_ptr       <= wrap_add(res_sel, 1);
            end
        end
    end
endmodule

// File: tb/tb_bs_engine_scheduler.sv
// Directed bench for bs_engine_scheduler: dispatch order, overflow, result
// arbitration and backpressure, protocol error and mid-flight reset.
module tb_bs_engine_scheduler;
    localparam int NUM_ENG = 4;
    localparam int W       = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 rec_valid;
    logic [W-1:0]         rec_option_id, rec_sptprice, rec_strike, rec_rate;
    logic [W-1:0]         rec_volatility, rec_otime, rec_otype;
    logic                 rec_ready;
    logic [NUM_ENG-1:0]   eng_start;
    logic [W-1:0]         eng_sptprice, eng_strike, eng_rate, eng_volatility, eng_otime, eng_otype;
    logic [NUM_ENG-1:0]   eng_done;
    logic [NUM_ENG*W-1:0] eng_price;
    logic                 res_valid, res_ready;
    logic [W-1:0]         res_option_id, res_price;
    logic [2:0]           res_engine;
    logic [15:0]          ovf_cnt;
    logic                 proto_err;

    int total = 0;
    int bad   = 0;

    bs_engine_scheduler #(.NUM_ENG(NUM_ENG), .W(W)) dut (
        .clk(clk), .rst(rst),
        .rec_valid(rec_valid), .rec_option_id(rec_option_id), .rec_sptprice(rec_sptprice),
        .rec_strike(rec_strike), .rec_rate(rec_rate), .rec_volatility(rec_volatility),
        .rec_otime(rec_otime), .rec_otype(rec_otype), .rec_ready(rec_ready),
        .eng_start(eng_start), .eng_sptprice(eng_sptprice), .eng_strike(eng_strike),
        .eng_rate(eng_rate), .eng_volatility(eng_volatility), .eng_otime(eng_otime),
        .eng_otype(eng_otype), .eng_done(eng_done), .eng_price(eng_price),
        .res_valid(res_valid), .res_ready(res_ready), .res_option_id(res_option_id),
        .res_price(res_price), .res_engine(res_engine), .ovf_cnt(ovf_cnt),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Record fields derive from the id so the operand bus can be checked.
    task automatic drive_rec(input int id);
        rec_valid      = 1'b1;
        rec_option_id  = W'(id);
        rec_sptprice   = W'(id * 16 + 1);
        rec_strike     = W'(id * 16 + 2);
        rec_rate       = W'(id * 16 + 3);
        rec_volatility = W'(id * 16 + 4);
        rec_otime      = W'(id * 16 + 5);
        rec_otype      = W'(id % 2);
    endtask

    task automatic chk_res(input string tag, input int id, input int pr, input int eng);
        chk({tag, "_valid"}, 64'(res_valid), 64'd1);
        chk({tag, "_id"}, 64'(res_option_id), 64'(id));
        chk({tag, "_price"}, 64'(res_price), 64'(pr));
        chk({tag, "_eng"}, 64'(res_engine), 64'(eng));
    endtask

    initial begin
        rst = 1'b0;
        rec_valid = 1'b0;
        rec_option_id = '0; rec_sptprice = '0; rec_strike = '0; rec_rate = '0;
        rec_volatility = '0; rec_otime = '0; rec_otype = '0;
        eng_done = '0; eng_price = '0; res_ready = 1'b0;
        tick(); tick();
        chk("rst_rec_ready", 64'(rec_ready), 64'd1);
        chk("rst_eng_start", 64'(eng_start), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_ovf", 64'(ovf_cnt), 64'd0);
        chk("rst_proto", 64'(proto_err), 64'd0);
        chk("rst_bus", 64'(eng_sptprice), 64'd0);

        rst = 1'b1;
        drive_rec(1);
        tick(); chk("start_1", 64'(eng_start), 64'b0001);
        chk("bus_spt_1", 64'(eng_sptprice), 64'd17);
        drive_rec(2);
        tick(); chk("start_2", 64'(eng_start), 64'b0010);
        drive_rec(3);
        tick(); chk("start_3", 64'(eng_start), 64'b0100);
        drive_rec(4);
        tick(); chk("start_4", 64'(eng_start), 64'b1000);
        chk("full_rec_ready", 64'(rec_ready), 64'd0);
        drive_rec(5);
        tick(); chk("drop_start", 64'(eng_start), 64'd0);
        chk("drop_ovf", 64'(ovf_cnt), 64'd1);
        chk("hold_spt", 64'(eng_sptprice), 64'd65);
        chk("hold_otime", 64'(eng_otime), 64'd69);
        chk("hold_otype", 64'(eng_otype), 64'd0);

        rec_valid = 1'b0;
        eng_done = 4'b0101;
        eng_price[2*W +: W] = 32'hAA;
        eng_price[0*W +: W] = 32'hBB;
        tick(); chk("done_no_res_yet", 64'(res_valid), 64'd0);
        eng_done = '0;
        res_ready = 1'b1;
        tick(); chk_res("res_a", 1, 32'hBB, 0);
        tick(); chk("res_a_drop", 64'(res_valid), 64'd0);
        chk("eng0_free", 64'(rec_ready), 64'd1);
        res_ready = 1'b0;
        drive_rec(6);
        tick(); chk_res("res_b", 3, 32'hAA, 2);
        chk("start_6", 64'(eng_start), 64'b0001);
        chk("full_again", 64'(rec_ready), 64'd0);
        rec_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_res("stall", 3, 32'hAA, 2);
            chk("stall_rec_ready", 64'(rec_ready), 64'd0);
        end
        res_ready = 1'b1;
        tick(); chk("res_b_drop", 64'(res_valid), 64'd0);
        chk("eng2_free", 64'(rec_ready), 64'd1);
        res_ready = 1'b0;
        drive_rec(7);
        tick(); chk("start_7", 64'(eng_start), 64'b0100);
        chk("bus_spt_7", 64'(eng_sptprice), 64'd113);
        chk("full_3", 64'(rec_ready), 64'd0);
        rec_valid = 1'b0;

        eng_done = 4'b0010;
        eng_price[1*W +: W] = 32'h11;
        tick(); eng_done = '0;
        chk("res_c_wait", 64'(res_valid), 64'd0);
        tick(); chk_res("res_c", 2, 32'h11, 1);
        res_ready = 1'b1;
        tick(); chk("res_c_drop", 64'(res_valid), 64'd0);
        res_ready = 1'b0;
        eng_done = 4'b0010;
        eng_price[1*W +: W] = 32'h22;
        tick(); chk("proto_set", 64'(proto_err), 64'd1);
        eng_done = '0;
        tick(); tick();
        chk("proto_sticky", 64'(proto_err), 64'd1);
        chk("proto_no_res", 64'(res_valid), 64'd0);

        eng_done = 4'b1000;
        eng_price[3*W +: W] = 32'h33;
        tick(); eng_done = '0;
        tick(); chk_res("res_d", 4, 32'h33, 3);

        #3 rst = 1'b0;
        #1;
        chk("arst_res_valid", 64'(res_valid), 64'd0);
        chk("arst_res_id", 64'(res_option_id), 64'd0);
        chk("arst_res_price", 64'(res_price), 64'd0);
        chk("arst_res_eng", 64'(res_engine), 64'd0);
        chk("arst_bus", 64'(eng_sptprice), 64'd0);
        chk("arst_ovf", 64'(ovf_cnt), 64'd0);
        chk("arst_proto", 64'(proto_err), 64'd0);
        chk("arst_rec_ready", 64'(rec_ready), 64'd1);
        tick();
        rst = 1'b1;
        drive_rec(9);
        tick(); chk("post_rst_start", 64'(eng_start), 64'b0001);
        chk("post_rst_spt", 64'(eng_sptprice), 64'd145);
        rec_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
